// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1:N stream demux
package demux_pkg;
  typedef enum logic {MODE_UNICAST, MODE_BROADCAST} mode_e;
  typedef enum logic [1:0] {F_EMPTY, F_ONE, F_FULL} fifo_state_e;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/demux_fifo2.sv
// rtl/demux_fifo2.sv - 2-entry per-channel buffer; head register drives the output directly
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full
);

  fifo_state_e state, state_nx;
  logic [W-1:0] head, tail;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (state != F_EMPTY);
  assign full      = (state == F_FULL);
  assign out_data  = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_EMPTY;
    else        state <= state_nx;
  end

  // Push in FULL cannot occur: the top withholds in_ready for full targets.
  always_comb begin
    state_nx = state;
    case (state)
      F_EMPTY: if (push) state_nx = F_ONE;
      F_ONE: begin
        if (push && !pop)      state_nx = F_FULL;
        else if (pop && !push) state_nx = F_EMPTY;
      end
      F_FULL:  if (pop) state_nx = F_ONE;
      default: state_nx = F_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        F_EMPTY: if (push) head <= push_data;
        F_ONE: begin
          if (push && pop) head <= push_data;
          else if (push)   tail <= push_data;
        end
        F_FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - 1:N demux, unicast or masked broadcast, buffered per channel
module stream_demux_n
  import demux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic                  in_mode,
  input  logic [SW-1:0]         in_sel,
  input  logic [N-1:0]          in_mask,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [N*W-1:0]        out_data,
  output logic                  err_sel,
  input  logic                  err_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  mode_e        mode;
  logic [N-1:0] hit, tgt, full, push;
  logic         sel_ok, accept;

  assign mode = mode_e'(in_mode);

  // Out-of-range select yields an all-zero hit vector, so the beat is dropped.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) hit[i] = (int'(in_sel) == i);
  end

  assign sel_ok = |hit;
  assign tgt    = (mode == MODE_BROADCAST) ? in_mask : hit;

  // Registered FIFO state only: no path from out_ready to in_ready.
  assign in_ready = rst_n && ((tgt & full) == '0);
  assign accept   = in_valid && in_ready;
  assign push     = {N{accept}} & tgt;

  for (genvar g = 0; g < N; g++) begin : g_ch
    demux_fifo2 #(.W(W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (in_data),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g*W +: W]),
      .full      (full[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err_sel <= 1'b0;
    else if (accept && mode == MODE_UNICAST && !sel_ok) err_sel <= 1'b1;
    else if (err_clr)                                   err_sel <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (accept && tgt == '0 && drop_cnt != DROP_MAX)
      drop_cnt <= drop_cnt + DROP_ONE;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised 1:N streaming demultiplexer with valid/ready handshaking and per-channel buffering. It is the sequential successor to the 1:2 and 1:4 combinational demux building blocks. It routes one input word per accepted beat either to a single selected channel (unicast) or to a masked set of channels (broadcast). Each channel sits behind a 2-entry FIFO, so output backpressure never creates a combinational path to `in_ready`. It sits between a single producer and N independent consumers in the datapath.

## Interface
- `N`, default 4: number of output channels, ≥2 (need not be a power of 2).
- `W`, default 8: data width in bits, ≥1.
- `SW`, default `$clog2(N)`: select width (derived, not overridden).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  W  input payload.
- `in_mode`  in  1  0 = unicast, 1 = broadcast (`demux_pkg::mode_e`).
- `in_sel`  in  SW  target channel in unicast mode.
- `in_mask`  in  N  target channel set in broadcast mode; bit i = channel i.
- `out_valid`  out  N  per-channel valid.
- `out_ready`  in  N  per-channel ready.
- `out_data`  out  N*W  channel i occupies bits [i*W +: W].
- `err_sel`  out  1  sticky: unicast beat with `in_sel >= N` was accepted.
- `err_clr`  in  1  synchronous clear of `err_sel`.
- `drop_cnt`  out  16  count of accepted beats that reached no channel, saturating at 0xFFFF.

## Operation
- Target vector T: in unicast mode, one-hot of `in_sel`, or all-zero if `in_sel >= N`. In broadcast mode, T = `in_mask`.
- `in_ready` = AND over i in T of `!full[i]`. If T = 0, `in_ready` = 1.
- `in_ready` depends only on registered FIFO state. It never depends on `out_ready` or a same-cycle pop.
- Accept (`in_valid && in_ready`): push `in_data` into every FIFO i with T[i] = 1, in the same cycle. Beats are never partially delivered.
- Accept with T = 0: the word is discarded and `drop_cnt` increments by 1 (saturating).
- Accept with unicast `in_sel >= N`: additionally set `err_sel`.
- `err_clr` and a setting event in the same cycle: the set wins.
- Per-channel FIFO: 2 entries, FIFO order. States EMPTY → ONE → FULL.
  - push-only moves up one state; pop-only moves down one state.
  - push and pop together in ONE stays in ONE, with data shifting.
  - push is never presented in FULL, because `in_ready` gates it.
- `out_valid[i]` = !EMPTY. `out_data` slice i = head entry of FIFO i.
- Pop when `out_valid[i] && out_ready[i]`. Channels drain fully independently.
- `in_mode`, `in_sel` and `in_mask` are sampled only on accept. Changing them while `in_valid` is held low has no effect.

## Timing
- Reset values (async assert, sync release): all FIFOs EMPTY, `out_valid` = 0, `out_data` = 0, `err_sel` = 0, `drop_cnt` = 0.
- `in_ready` during reset = 0. After release, `in_ready` = 1 until a target FIFO fills.
- Latency: a beat accepted at edge t gives `out_valid` high after edge t, i.e. it is visible in cycle t+1.
- Throughput: one beat/cycle per channel when the consumer holds `out_ready` = 1.
  - Steady state keeps the FIFO in ONE.
  - With `in_ready` registered-only, no bubble is inserted.
- Backpressure: with `out_ready[i]` = 0, channel i accepts exactly 2 beats. `in_ready` then drops for any T including i, and reasserts the cycle after the first pop.
- Broadcast stall: if any masked channel is FULL, the beat waits. Other channels still drain.
- `rst_n` asserted mid-transfer: all buffered words are lost and outputs return to reset values immediately. There is no clock requirement.
- `out_valid[i]` must not drop without a pop. `out_data` slice i is stable while `out_valid[i] && !out_ready[i]`.

## Structure
- `demux_pkg`: `typedef enum logic {MODE_UNICAST, MODE_BROADCAST} mode_e`; `typedef enum logic [1:0] {F_EMPTY, F_ONE, F_FULL} fifo_state_e`; `localparam DROP_CNT_W = 16`.
- Sub-module `demux_fifo2` (params `W`): push/data in, valid/ready/data out, `full` out, state in `fifo_state_e`.
- The top instantiates `demux_fifo2` N times in a generate loop, plus target decode, accept logic, `err_sel` and `drop_cnt`.

## Test plan
- Unicast 0xA5 to sel=2, all `out_ready` = 1 → `out_valid` = 4'b0100 next cycle, slice 2 = 0xA5, popped one cycle later; `drop_cnt` = 0.
- Backpressure: `out_ready[1]` = 0, send 0x11, 0x22, 0x33 to sel=1 → first two accepted, `in_ready` = 0 on the third. Raise `out_ready[1]` → outputs 0x11, 0x22, 0x33 in order, with no loss or duplicate.
- Broadcast mask 4'b1011, data 0x5C, `out_ready[3]` = 0 with FIFO 3 FULL → `in_ready` = 0. Free FIFO 3 → 0x5C appears on channels 0, 1 and 3 in the same cycle, and channel 2 stays idle.
- N=3 build, unicast sel=3 → beat accepted, no `out_valid`, `err_sel` = 1, `drop_cnt` = 1. Apply `err_clr` → `err_sel` = 0; `drop_cnt` holds.
- Broadcast mask 0 repeated 70000 beats → `drop_cnt` saturates at 0xFFFF.
- Fill channels 0 and 2, assert `rst_n` = 0 mid-cycle → `out_valid` = 0 asynchronously. After release, `in_ready` = 1 and no stale data is emitted.
